// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer time-sharing one full_adder cell
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sum_msb;
  logic [WIDTH-1:0] sum_sh_next;

  // The single adder cell always sees the current LSBs and the running carry
  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB
  always_comb begin
    sum_msb            = '0;
    sum_msb[WIDTH-1]   = fa_sum;
    sum_sh_next        = (sum_sh_q >> 1) | sum_msb;
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, shift one bit per RUN cycle
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_out_d = sum_out_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_sh_next;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        // Result registers only change on entry to DONE, so they hold the
        // previous answer while a new operation is being computed
        if (last_bit) begin
          sum_out_d = sum_sh_next;
          cout_d    = fa_cout;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; reset discards any in-flight or pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_out_q <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_out_q <= sum_out_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign sum_out   = sum_out_q;
  assign cout_out  = cout_q;

endmodule

// One-bit full adder cell shared by the sequencer
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid8 = 1'b0, in_ready8, busy8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cin8 = 1'b0, cout8;

  logic       in_valid1 = 1'b0, in_ready1, busy1, out_valid1, out_ready1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       cin1 = 1'b0, cout1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc8 = 0, acc1 = 0;
  int last_acc8 = -1, last_acc1 = -1;

  logic [8:0] sb8[$];
  logic [1:0] sb1[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(a8), .b_in(b8), .cin_in(cin8), .busy(busy8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum_out(sum8), .cout_out(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a1), .b_in(b1), .cin_in(cin1), .busy(busy1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum_out(sum1), .cout_out(cout1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept handshake, pop and compare on output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid8 && in_ready8) begin
        sb8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        if (last_acc8 >= 0) check("ii_w8", 32'(cyc - last_acc8 >= 10), 32'd1);
        last_acc8 = cyc;
        acc8++;
      end
      if (out_valid8 && out_ready8) begin
        check("sb8_nonempty", 32'(sb8.size() != 0), 32'd1);
        if (sb8.size() != 0) check("sb8_result", 32'({cout8, sum8}), 32'(sb8.pop_front()));
      end
      if (in_valid1 && in_ready1) begin
        sb1.push_back(2'(a1) + 2'(b1) + 2'(cin1));
        if (last_acc1 >= 0) check("ii_w1", 32'(cyc - last_acc1 >= 3), 32'd1);
        last_acc1 = cyc;
        acc1++;
      end
      if (out_valid1 && out_ready1) begin
        check("sb1_nonempty", 32'(sb1.size() != 0), 32'd1);
        if (sb1.size() != 0) check("sb1_result", 32'({cout1, sum1}), 32'(sb1.pop_front()));
      end
    end
  end

  task automatic wait_out8(input string tag);
    int n = 0;
    while (!out_valid8 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(out_valid8), 32'd1);
  endtask

  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es, input logic ec);
    a8 = a; b8 = b; cin8 = cin; in_valid8 = 1'b1; out_ready8 = 1'b0;
    step();
    in_valid8 = 1'b0;
    wait_out8(tag);
    check({tag, "_sum"}, 32'(sum8), 32'(es));
    check({tag, "_cout"}, 32'(cout8), 32'(ec));
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
  endtask

  initial begin
    int n;
    int busy_cnt;
    int seen;
    int lim;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready8), 32'd1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    rst = 1'b0;
    step();

    // 0x5A + 0x3C: latency and busy duration, then 5 cycles of backpressure
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    n = 0; busy_cnt = 0;
    while (!out_valid8 && n < 40) begin
      if (busy8) busy_cnt++;
      step();
      n++;
    end
    check("lat_edges", 32'(n), 32'd8);
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid8), 32'd1);
      check("bp_sum", 32'(sum8), 32'h96);
      check("bp_cout", 32'(cout8), 32'd0);
      check("bp_in_ready", 32'(in_ready8), 32'd0);
      step();
    end
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    check("handoff_in_ready", 32'(in_ready8), 32'd1);
    check("handoff_out_valid", 32'(out_valid8), 32'd0);
    check("hold_sum_after_done", 32'(sum8), 32'h96);

    // Carry propagation corners
    run_op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // in_valid pulsed during RUN is ignored
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    step();
    a8 = 8'h11; b8 = 8'h00; in_valid8 = 1'b1;
    check("run_in_ready", 32'(in_ready8), 32'd0);
    step();
    in_valid8 = 1'b0;
    wait_out8("ignore");
    check("ignore_sum", 32'(sum8), 32'h96);
    check("ignore_cout", 32'(cout8), 32'd0);
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    check("ignore_sb_drained", 32'(sb8.size()), 32'd0);

    // Reset during the 4th RUN cycle discards the operation
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready8), 32'd1);
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid8), 32'd0);
    check("mid_rst_sum", 32'(sum8), 32'd0);
    check("mid_rst_cout", 32'(cout8), 32'd0);
    sb8.delete();
    sb1.delete();
    last_acc8 = -1;
    last_acc1 = -1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) seen++;
      step();
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    run_op8("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Random back-to-back traffic on both widths with random backpressure
    lim = 0;
    acc8 = 0;
    acc1 = 0;
    while ((acc8 < 600 || acc1 < 400) && lim < 30000) begin
      in_valid8  = ($urandom_range(0, 3) != 0);
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      cin8       = 1'($urandom);
      out_ready8 = 1'($urandom);
      in_valid1  = ($urandom_range(0, 3) != 0);
      a1         = 1'($urandom);
      b1         = 1'($urandom);
      cin1       = 1'($urandom);
      out_ready1 = 1'($urandom);
      step();
      lim++;
    end
    check("rand_w8_ops", 32'(acc8 >= 600), 32'd1);
    check("rand_w1_ops", 32'(acc1 >= 400), 32'd1);
    in_valid8 = 1'b0; in_valid1 = 1'b0;
    out_ready8 = 1'b1; out_ready1 = 1'b1;
    n = 0;
    while ((sb8.size() != 0 || sb1.size() != 0) && n < 50) begin
      step();
      n++;
    end
    check("drain_sb8", 32'(sb8.size()), 32'd0);
    check("drain_sb1", 32'(sb1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
